// File: rtl/gated_clk_cell.sv
// Clock gate: enable sampled in the low phase so clk_out never glitches; zero latency.
// No backpressure; scan enable forces the clock on.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en_bf_latch;
    logic clk_en_q;

    assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

    // Low-phase capture behaves as the transparent-low latch of a real ICG.
    always_ff @(negedge clk_in) begin
        clk_en_q <= clk_en_bf_latch | pad_yy_icg_scan_en;
    end

    assign clk_out = clk_in & clk_en_q;

endmodule

// File: rtl/ct_idu_is_mat_cfg_issue.sv
// pipe8 matrix-cfg in-order issue queue + RF stage; a ready create reaches RF 2 cycles later.
// No downstream backpressure; dispatch must not create while cfg_iq_full.
module ct_idu_is_mat_cfg_issue #(
    parameter int DEPTH    = 4,
    parameter int PTR_W    = 2,
    parameter int WAKE_NUM = 3
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  cp0_mat_icg_en,
    input  logic                  cp0_yy_clk_en,
    input  logic                  pad_yy_icg_scan_en,
    input  logic                  rtu_yy_xx_flush,
    input  logic                  dis_cfg_create_vld,
    input  logic [6:0]            dis_cfg_create_iid,
    input  logic [3:0]            dis_cfg_create_meta,
    input  logic                  dis_cfg_create_dst_vld,
    input  logic [6:0]            dis_cfg_create_dst_preg,
    input  logic                  dis_cfg_create_src0_vld,
    input  logic [6:0]            dis_cfg_create_src0_preg,
    input  logic                  dis_cfg_create_src0_rdy,
    input  logic [WAKE_NUM-1:0]   x_wb_wakeup_vld,
    input  logic [7*WAKE_NUM-1:0] x_wb_wakeup_preg,
    input  logic [63:0]           pregfile_cfg_src0_data,
    output logic [6:0]            idu_rf_cfg_src0_preg,
    output logic                  cfg_iq_full,
    output logic                  cfg_iq_empty,
    output logic                  idu_mat_rf_cfg_sel,
    output logic                  idu_mat_rf_cfg_gateclk_sel,
    output logic [6:0]            idu_mat_rf_pipe8_iid,
    output logic [3:0]            idu_mat_rf_pipe8_cfg_meta,
    output logic                  idu_mat_rf_pipe8_cfg_dst_vld,
    output logic [6:0]            idu_mat_rf_pipe8_cfg_dst_preg,
    output logic [63:0]           idu_mat_rf_pipe8_cfg_src0
);

    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [6:0] iid;
        logic [3:0] meta;
        logic       dst_vld;
        logic [6:0] dst_preg;
        logic       src0_vld;
        logic [6:0] src0_preg;
    } cfg_ent_t;

    function automatic logic wake_hit(
        input logic [6:0]            preg,
        input logic [WAKE_NUM-1:0]   vld,
        input logic [7*WAKE_NUM-1:0] pregs
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < WAKE_NUM; i++) begin
            if (vld[i] && (pregs[7*i +: 7] == preg)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_rdy;
    logic [DEPTH-1:0] ent_wake;
    cfg_ent_t         ent_dat [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             rf_vld;
    cfg_ent_t         rf_ent;

    logic             create_en;
    logic             create_rdy;
    cfg_ent_t         create_ent;
    logic             issue;
    logic             ctrl_clk_en;
    logic             ctrl_clk;
    logic             rf_clk;

    assign cfg_iq_full  = (cnt == CNT_W'(DEPTH));
    assign cfg_iq_empty = (cnt == '0);

    assign create_en  = dis_cfg_create_vld & ~cfg_iq_full & ~rtu_yy_xx_flush;
    assign create_rdy = ~dis_cfg_create_src0_vld | dis_cfg_create_src0_rdy
                      | wake_hit(dis_cfg_create_src0_preg, x_wb_wakeup_vld, x_wb_wakeup_preg);

    always_comb begin
        create_ent           = '0;
        create_ent.iid       = dis_cfg_create_iid;
        create_ent.meta      = dis_cfg_create_meta;
        create_ent.dst_vld   = dis_cfg_create_dst_vld;
        create_ent.dst_preg  = dis_cfg_create_dst_preg;
        create_ent.src0_vld  = dis_cfg_create_src0_vld;
        create_ent.src0_preg = dis_cfg_create_src0_preg;
    end

    assign issue = ent_vld[rd_ptr] & ent_rdy[rd_ptr] & ~rtu_yy_xx_flush;

    // Payload storage: each entry only clocks on its own create.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic     ent_wen;
        logic     ent_clk;
        cfg_ent_t ent_q;

        assign ent_wen = create_en & (wr_ptr == PTR_W'(g));

        gated_clk_cell x_ent_gclk (
            .clk_in             (forever_cpuclk),
            .global_en          (cp0_yy_clk_en),
            .module_en          (cp0_mat_icg_en),
            .local_en           (ent_wen),
            .external_en        (1'b0),
            .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
            .clk_out            (ent_clk)
        );

        always_ff @(posedge ent_clk or negedge cpurst_b) begin
            if (!cpurst_b) begin
                ent_q <= '0;
            end else if (ent_wen) begin
                ent_q <= create_ent;
            end
        end

        assign ent_dat[g]  = ent_q;
        assign ent_wake[g] = wake_hit(ent_q.src0_preg, x_wb_wakeup_vld, x_wb_wakeup_preg);
    end

    assign ctrl_clk_en = dis_cfg_create_vld | (cnt != '0) | rf_vld;

    gated_clk_cell x_ctrl_gclk (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_mat_icg_en),
        .local_en           (ctrl_clk_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (ctrl_clk)
    );

    always_ff @(posedge ctrl_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ent_vld <= '0;
            ent_rdy <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            rf_vld  <= 1'b0;
        end else if (rtu_yy_xx_flush) begin
            ent_vld <= '0;
            ent_rdy <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            rf_vld  <= 1'b0;
        end else begin
            // Create and pop never target the same slot: create is blocked when full.
            for (int i = 0; i < DEPTH; i++) begin
                if (create_en && (wr_ptr == PTR_W'(i))) begin
                    ent_vld[i] <= 1'b1;
                    ent_rdy[i] <= create_rdy;
                end else if (issue && (rd_ptr == PTR_W'(i))) begin
                    ent_vld[i] <= 1'b0;
                    ent_rdy[i] <= 1'b0;
                end else if (ent_vld[i] && !ent_rdy[i] && ent_wake[i]) begin
                    ent_rdy[i] <= 1'b1;
                end
            end
            if (create_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (create_en && !issue) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!create_en && issue) begin
                cnt <= cnt - CNT_W'(1);
            end
            rf_vld <= issue;
        end
    end

    gated_clk_cell x_rf_gclk (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_mat_icg_en),
        .local_en           (issue),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (rf_clk)
    );

    always_ff @(posedge rf_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rf_ent <= '0;
        end else if (issue) begin
            rf_ent <= ent_dat[rd_ptr];
        end
    end

    assign idu_mat_rf_cfg_gateclk_sel    = rf_vld;
    assign idu_mat_rf_cfg_sel            = rf_vld & ~rtu_yy_xx_flush;
    assign idu_mat_rf_pipe8_iid          = rf_ent.iid;
    assign idu_mat_rf_pipe8_cfg_meta     = rf_ent.meta;
    assign idu_mat_rf_pipe8_cfg_dst_vld  = rf_ent.dst_vld;
    assign idu_mat_rf_pipe8_cfg_dst_preg = rf_ent.dst_preg;
    assign idu_rf_cfg_src0_preg          = rf_ent.src0_preg;
    assign idu_mat_rf_pipe8_cfg_src0     = rf_ent.src0_vld ? pregfile_cfg_src0_data : 64'b0;

endmodule

// File: tb/tb_ct_idu_is_mat_cfg_issue.sv
// Directed bench for the pipe8 matrix-cfg issue queue: table of per-cycle vectors
// followed by hand-written full/wrap and flush sequences.
module tb_ct_idu_is_mat_cfg_issue;

    localparam logic [63:0] PDATA = 64'h0000_0000_0040_1020;

    logic        forever_cpuclk;
    logic        cpurst_b;
    logic        cp0_mat_icg_en;
    logic        cp0_yy_clk_en;
    logic        pad_yy_icg_scan_en;
    logic        rtu_yy_xx_flush;
    logic        dis_cfg_create_vld;
    logic [6:0]  dis_cfg_create_iid;
    logic [3:0]  dis_cfg_create_meta;
    logic        dis_cfg_create_dst_vld;
    logic [6:0]  dis_cfg_create_dst_preg;
    logic        dis_cfg_create_src0_vld;
    logic [6:0]  dis_cfg_create_src0_preg;
    logic        dis_cfg_create_src0_rdy;
    logic [2:0]  x_wb_wakeup_vld;
    logic [20:0] x_wb_wakeup_preg;
    logic [63:0] pregfile_cfg_src0_data;
    logic [6:0]  idu_rf_cfg_src0_preg;
    logic        cfg_iq_full;
    logic        cfg_iq_empty;
    logic        idu_mat_rf_cfg_sel;
    logic        idu_mat_rf_cfg_gateclk_sel;
    logic [6:0]  idu_mat_rf_pipe8_iid;
    logic [3:0]  idu_mat_rf_pipe8_cfg_meta;
    logic        idu_mat_rf_pipe8_cfg_dst_vld;
    logic [6:0]  idu_mat_rf_pipe8_cfg_dst_preg;
    logic [63:0] idu_mat_rf_pipe8_cfg_src0;

    ct_idu_is_mat_cfg_issue #(.DEPTH(4), .PTR_W(2), .WAKE_NUM(3)) dut (
        .forever_cpuclk                (forever_cpuclk),
        .cpurst_b                      (cpurst_b),
        .cp0_mat_icg_en                (cp0_mat_icg_en),
        .cp0_yy_clk_en                 (cp0_yy_clk_en),
        .pad_yy_icg_scan_en            (pad_yy_icg_scan_en),
        .rtu_yy_xx_flush               (rtu_yy_xx_flush),
        .dis_cfg_create_vld            (dis_cfg_create_vld),
        .dis_cfg_create_iid            (dis_cfg_create_iid),
        .dis_cfg_create_meta           (dis_cfg_create_meta),
        .dis_cfg_create_dst_vld        (dis_cfg_create_dst_vld),
        .dis_cfg_create_dst_preg       (dis_cfg_create_dst_preg),
        .dis_cfg_create_src0_vld       (dis_cfg_create_src0_vld),
        .dis_cfg_create_src0_preg      (dis_cfg_create_src0_preg),
        .dis_cfg_create_src0_rdy       (dis_cfg_create_src0_rdy),
        .x_wb_wakeup_vld               (x_wb_wakeup_vld),
        .x_wb_wakeup_preg              (x_wb_wakeup_preg),
        .pregfile_cfg_src0_data        (pregfile_cfg_src0_data),
        .idu_rf_cfg_src0_preg          (idu_rf_cfg_src0_preg),
        .cfg_iq_full                   (cfg_iq_full),
        .cfg_iq_empty                  (cfg_iq_empty),
        .idu_mat_rf_cfg_sel            (idu_mat_rf_cfg_sel),
        .idu_mat_rf_cfg_gateclk_sel    (idu_mat_rf_cfg_gateclk_sel),
        .idu_mat_rf_pipe8_iid          (idu_mat_rf_pipe8_iid),
        .idu_mat_rf_pipe8_cfg_meta     (idu_mat_rf_pipe8_cfg_meta),
        .idu_mat_rf_pipe8_cfg_dst_vld  (idu_mat_rf_pipe8_cfg_dst_vld),
        .idu_mat_rf_pipe8_cfg_dst_preg (idu_mat_rf_pipe8_cfg_dst_preg),
        .idu_mat_rf_pipe8_cfg_src0     (idu_mat_rf_pipe8_cfg_src0)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    typedef struct {
        logic        c_vld;
        logic [6:0]  c_iid;
        logic [3:0]  c_meta;
        logic        c_dvld;
        logic [6:0]  c_dpreg;
        logic        c_svld;
        logic [6:0]  c_spreg;
        logic        c_srdy;
        logic [2:0]  w_vld;
        logic [20:0] w_preg;
        logic        flush;
        logic        e_sel;
        logic        e_gsel;
        logic [6:0]  e_iid;
        logic [3:0]  e_meta;
        logic        e_dvld;
        logic [6:0]  e_dpreg;
        logic [6:0]  e_spreg;
        logic [63:0] e_src0;
        logic        e_full;
        logic        e_empty;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    vec_t       tbl[$];
    logic [6:0] sel_q[$];

    always @(negedge forever_cpuclk) begin
        if (cpurst_b && idu_mat_rf_cfg_sel) sel_q.push_back(idu_mat_rf_pipe8_iid);
    end

    always @(posedge forever_cpuclk) begin
        if (cpurst_b) assert (!(dis_cfg_create_vld && cfg_iq_full)) else $error("illegal create while queue full");
    end

    function automatic logic [20:0] wp(input int p, input logic [6:0] preg);
        logic [20:0] r;
        r = '0;
        r[7*p +: 7] = preg;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        rtu_yy_xx_flush          = 1'b0;
        dis_cfg_create_vld       = 1'b0;
        dis_cfg_create_iid       = '0;
        dis_cfg_create_meta      = '0;
        dis_cfg_create_dst_vld   = 1'b0;
        dis_cfg_create_dst_preg  = '0;
        dis_cfg_create_src0_vld  = 1'b0;
        dis_cfg_create_src0_preg = '0;
        dis_cfg_create_src0_rdy  = 1'b0;
        x_wb_wakeup_vld          = '0;
        x_wb_wakeup_preg         = '0;
    endtask

    task automatic create(input logic [6:0] iid, input logic svld, input logic [6:0] spreg, input logic srdy);
        dis_cfg_create_vld       = 1'b1;
        dis_cfg_create_iid       = iid;
        dis_cfg_create_meta      = 4'b0001;
        dis_cfg_create_dst_vld   = 1'b0;
        dis_cfg_create_dst_preg  = '0;
        dis_cfg_create_src0_vld  = svld;
        dis_cfg_create_src0_preg = spreg;
        dis_cfg_create_src0_rdy  = srdy;
    endtask

    task automatic wake(input int p, input logic [6:0] preg);
        x_wb_wakeup_vld[p]          = 1'b1;
        x_wb_wakeup_preg[7*p +: 7] = preg;
    endtask

    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
    endtask

    initial begin
        cpurst_b               = 1'b0;
        cp0_mat_icg_en         = 1'b0;
        cp0_yy_clk_en          = 1'b1;
        pad_yy_icg_scan_en     = 1'b0;
        pregfile_cfg_src0_data = PDATA;
        idle_in();

        // create / wake / same-cycle wake / ready-at-create, one row per cycle
        tbl.push_back('{1'b1, 7'd5, 4'b0001, 1'b1, 7'h21, '0, '0, '0, '0, '0, '0,             '0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b1});
        tbl.push_back('{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0,                           '0, '0, '0, '0, '0, '0, '0, '0, '0, '0});
        tbl.push_back('{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0,                           1'b1, 1'b1, 7'd5, 4'b0001, 1'b1, 7'h21, '0, '0, '0, 1'b1});
        tbl.push_back('{1'b1, 7'd6, 4'b0010, '0, '0, 1'b1, 7'h10, '0, '0, '0, '0,             '0, '0, 7'd5, 4'b0001, 1'b1, 7'h21, '0, '0, '0, 1'b1});
        tbl.push_back('{'0, '0, '0, '0, '0, '0, '0, '0, 3'b001, wp(0, 7'h11), '0,             '0, '0, 7'd5, 4'b0001, 1'b1, 7'h21, '0, '0, '0, '0});
        tbl.push_back('{'0, '0, '0, '0, '0, '0, '0, '0, 3'b010, wp(1, 7'h10), '0,             '0, '0, 7'd5, 4'b0001, 1'b1, 7'h21, '0, '0, '0, '0});
        tbl.push_back('{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0,                           '0, '0, 7'd5, 4'b0001, 1'b1, 7'h21, '0, '0, '0, '0});
        tbl.push_back('{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0,                           1'b1, 1'b1, 7'd6, 4'b0010, '0, '0, 7'h10, PDATA, '0, 1'b1});
        tbl.push_back('{1'b1, 7'd7, 4'b0100, 1'b1, 7'h33, 1'b1, 7'h22, '0, 3'b100, wp(2, 7'h22), '0, '0, '0, 7'd6, 4'b0010, '0, '0, 7'h10, PDATA, '0, 1'b1});
        tbl.push_back('{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0,                           '0, '0, 7'd6, 4'b0010, '0, '0, 7'h10, PDATA, '0, '0});
        tbl.push_back('{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0,                           1'b1, 1'b1, 7'd7, 4'b0100, 1'b1, 7'h33, 7'h22, PDATA, '0, 1'b1});
        tbl.push_back('{1'b1, 7'd8, 4'b1000, '0, '0, 1'b1, 7'h05, 1'b1, '0, '0, '0,           '0, '0, 7'd7, 4'b0100, 1'b1, 7'h33, 7'h22, PDATA, '0, 1'b1});
        tbl.push_back('{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0,                           '0, '0, 7'd7, 4'b0100, 1'b1, 7'h33, 7'h22, PDATA, '0, '0});
        tbl.push_back('{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0,                           1'b1, 1'b1, 7'd8, 4'b1000, '0, '0, 7'h05, PDATA, '0, 1'b1});

        repeat (3) @(posedge forever_cpuclk);
        #1 cpurst_b = 1'b1;
        #1;
        chk("rst_empty", 64'(cfg_iq_empty), 64'd1);
        chk("rst_full", 64'(cfg_iq_full), 64'd0);
        chk("rst_sel", 64'(idu_mat_rf_cfg_sel), 64'd0);
        chk("rst_gsel", 64'(idu_mat_rf_cfg_gateclk_sel), 64'd0);
        chk("rst_src0", idu_mat_rf_pipe8_cfg_src0, 64'd0);
        chk("rst_rdidx", 64'(idu_rf_cfg_src0_preg), 64'd0);

        for (int k = 0; k < tbl.size(); k++) begin
            dis_cfg_create_vld       = tbl[k].c_vld;
            dis_cfg_create_iid       = tbl[k].c_iid;
            dis_cfg_create_meta      = tbl[k].c_meta;
            dis_cfg_create_dst_vld   = tbl[k].c_dvld;
            dis_cfg_create_dst_preg  = tbl[k].c_dpreg;
            dis_cfg_create_src0_vld  = tbl[k].c_svld;
            dis_cfg_create_src0_preg = tbl[k].c_spreg;
            dis_cfg_create_src0_rdy  = tbl[k].c_srdy;
            x_wb_wakeup_vld          = tbl[k].w_vld;
            x_wb_wakeup_preg         = tbl[k].w_preg;
            rtu_yy_xx_flush          = tbl[k].flush;
            #1;
            chk($sformatf("v%0d_sel", k), 64'(idu_mat_rf_cfg_sel), 64'(tbl[k].e_sel));
            chk($sformatf("v%0d_gsel", k), 64'(idu_mat_rf_cfg_gateclk_sel), 64'(tbl[k].e_gsel));
            chk($sformatf("v%0d_iid", k), 64'(idu_mat_rf_pipe8_iid), 64'(tbl[k].e_iid));
            chk($sformatf("v%0d_meta", k), 64'(idu_mat_rf_pipe8_cfg_meta), 64'(tbl[k].e_meta));
            chk($sformatf("v%0d_dvld", k), 64'(idu_mat_rf_pipe8_cfg_dst_vld), 64'(tbl[k].e_dvld));
            chk($sformatf("v%0d_dpreg", k), 64'(idu_mat_rf_pipe8_cfg_dst_preg), 64'(tbl[k].e_dpreg));
            chk($sformatf("v%0d_rdidx", k), 64'(idu_rf_cfg_src0_preg), 64'(tbl[k].e_spreg));
            chk($sformatf("v%0d_src0", k), idu_mat_rf_pipe8_cfg_src0, tbl[k].e_src0);
            chk($sformatf("v%0d_full", k), 64'(cfg_iq_full), 64'(tbl[k].e_full));
            chk($sformatf("v%0d_empty", k), 64'(cfg_iq_empty), 64'(tbl[k].e_empty));
            tick();
        end

        // Fill to DEPTH with blocked entries, then release out of order.
        idle_in();
        sel_q.delete();
        for (int i = 0; i < 4; i++) begin
            create(7'(20 + i), 1'b1, 7'(7'h40 + i), 1'b0);
            tick();
        end
        idle_in();
        chk("full_set", 64'(cfg_iq_full), 64'd1);
        chk("full_not_empty", 64'(cfg_iq_empty), 64'd0);
        wake(0, 7'h40);
        tick();
        idle_in();
        wake(1, 7'h43);
        wake(2, 7'h42);
        #1;
        chk("full_issue_cycle", 64'(cfg_iq_full), 64'd1);
        tick();
        idle_in();
        wake(0, 7'h41);
        #1;
        chk("full_fall", 64'(cfg_iq_full), 64'd0);
        chk("first_sel", 64'(idu_mat_rf_cfg_sel), 64'd1);
        chk("first_iid", 64'(idu_mat_rf_pipe8_iid), 64'd20);
        tick();
        idle_in();
        repeat (6) tick();
        chk("order_cnt", 64'(sel_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < sel_q.size(); i++) chk($sformatf("order_%0d", i), 64'(sel_q[i]), 64'(20 + i));
        chk("drain_empty", 64'(cfg_iq_empty), 64'd1);

        // Second lap around the ring: back-to-back ready creates.
        sel_q.delete();
        for (int i = 0; i < 4; i++) begin
            create(7'(30 + i), 1'b0, 7'h00, 1'b0);
            tick();
        end
        idle_in();
        repeat (4) tick();
        chk("wrap_cnt", 64'(sel_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < sel_q.size(); i++) chk($sformatf("wrap_%0d", i), 64'(sel_q[i]), 64'(30 + i));

        // Flush with three queued entries and one instruction in RF.
        sel_q.delete();
        create(7'd40, 1'b1, 7'h50, 1'b0); tick();
        create(7'd41, 1'b1, 7'h51, 1'b0); tick();
        create(7'd42, 1'b1, 7'h51, 1'b0); tick();
        create(7'd43, 1'b1, 7'h51, 1'b0); wake(0, 7'h50); tick();
        idle_in(); tick();
        rtu_yy_xx_flush = 1'b1;
        create(7'd44, 1'b0, 7'h00, 1'b1);
        wake(1, 7'h51);
        #1;
        chk("flush_sel", 64'(idu_mat_rf_cfg_sel), 64'd0);
        chk("flush_gsel", 64'(idu_mat_rf_cfg_gateclk_sel), 64'd1);
        chk("flush_rf_iid", 64'(idu_mat_rf_pipe8_iid), 64'd40);
        tick();
        idle_in();
        #1;
        chk("post_flush_empty", 64'(cfg_iq_empty), 64'd1);
        chk("post_flush_gsel", 64'(idu_mat_rf_cfg_gateclk_sel), 64'd0);
        wake(0, 7'h51);
        tick();
        idle_in();
        repeat (4) tick();
        chk("post_flush_no_sel", 64'(sel_q.size()), 64'd0);
        chk("post_flush_still_empty", 64'(cfg_iq_empty), 64'd1);
        create(7'd45, 1'b0, 7'h00, 1'b1);
        tick();
        idle_in();
        tick();
        chk("restart_sel", 64'(idu_mat_rf_cfg_sel), 64'd1);
        chk("restart_iid", 64'(idu_mat_rf_pipe8_iid), 64'd45);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
